cfg_chain_loader: RTL

CFG_CHAIN_LOADER -- requirements
Module: cfg_chain_loader

---
 rtl/cfg_pkg.sv | 14 +
 rtl/cfg_piso.sv | 39 +++
 rtl/cfg_chain_loader.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cfg_pkg.sv
// Shared types and default sizing for the configuration-chain loader.
package cfg_pkg;

    localparam int WORD_W_DEFAULT    = 8;
    localparam int CHAIN_LEN_DEFAULT = 48;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/cfg_piso.sv
// Parallel-in serial-out word register; the MSB is presented first.
module cfg_piso #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [WORD_W-1:0] data_i,
    output logic              msb_o
);

    logic [WORD_W-1:0] shreg_q;
    logic [WORD_W-1:0] shreg_d;

    // Next value: load has priority over shift.
    always_comb begin
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d = data_i;
        end else if (shift_i) begin
            shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
        end else begin
            shreg_d = shreg_q;
        end
    end

    // Word register with asynchronous clear.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign msb_o = shreg_q[WORD_W-1];

endmodule

// File: rtl/cfg_chain_loader.sv
// Streams host configuration words, MSB first, into a serial config chain
// of CHAIN_LEN bits, with stall, abort and completion signalling.
module cfg_chain_loader
    import cfg_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEFAULT,
    parameter int CHAIN_LEN = CHAIN_LEN_DEFAULT
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] wdata,
    input  logic              wvalid,
    output logic              wready,
    output logic              cfg_en,
    output logic              cfg_shift,
    output logic              cfg_data,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam int REM_W = $clog2(CHAIN_LEN + 1);
    localparam int BIT_W = $clog2(WORD_W + 1);

    state_e           state_q, state_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [BIT_W-1:0] wbits_q, wbits_d;
    logic             cfg_en_q, cfg_shift_q, wready_q, busy_q, done_q, aborted_q;
    logic             load_s, shift_s, msb_s;

    assign load_s  = (state_q == ST_FETCH) && wvalid && !abort;
    assign shift_s = (state_q == ST_SHIFT) && !abort;

    cfg_piso #(.WORD_W(WORD_W)) u_piso (
        .clk    (clk),
        .nrst   (nrst),
        .load_i (load_s),
        .shift_i(shift_s),
        .data_i (wdata),
        .msb_o  (msb_s)
    );

    // Next-state and counter logic; abort wins over every other request.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        wbits_d = wbits_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    rem_d   = REM_W'(CHAIN_LEN);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (wvalid) begin
                    state_d = ST_SHIFT;
                    if (int'(rem_q) < WORD_W) begin
                        wbits_d = BIT_W'(rem_q);
                    end else begin
                        wbits_d = BIT_W'(WORD_W);
                    end
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    rem_d   = (rem_q != '0) ? rem_q - REM_W'(1) : '0;
                    wbits_d = (wbits_q != '0) ? wbits_q - BIT_W'(1) : '0;
                    if (wbits_q <= BIT_W'(1)) begin
                        state_d = (rem_q <= REM_W'(1)) ? ST_DONE : ST_FETCH;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and output flags, all registered from the next state.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            wbits_q     <= '0;
            cfg_en_q    <= 1'b0;
            cfg_shift_q <= 1'b0;
            wready_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            wbits_q     <= wbits_d;
            cfg_en_q    <= (state_d == ST_FETCH) || (state_d == ST_SHIFT);
            cfg_shift_q <= (state_d == ST_SHIFT);
            wready_q    <= (state_d == ST_FETCH);
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_d == ST_DONE);
            aborted_q   <= abort && (state_q != ST_IDLE);
        end
    end

    assign cfg_en    = cfg_en_q;
    assign cfg_shift = cfg_shift_q;
    assign cfg_data  = cfg_shift_q & msb_s;
    assign wready    = wready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;

endmodule
